minterm_sweeper: RTL and testbench

Parametrised, clocked truth-table evaluator: holds a programmable N-input boolean function as a minterm mask. It answers single-point evaluations with one-cycle latency and, on request, sweeps every input combination in ascending order. Sweep results stream out over a valid/ready handshake. It is the sequential, width-generic successor of the team's fixed two-input gate-level minterm circuits and sits between stimulus/control logic and any truth-table consumer (display, checker, scoreboard).

---
 rtl/minterm_pkg.sv | 11 +
 rtl/minterm_lut.sv | 28 ++
 rtl/minterm_sweeper.sv | 116 +++++++++++
 tb/tb_minterm_sweeper.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/minterm_pkg.sv
// minterm_pkg: shared types and limits for the minterm sweeper block.
package minterm_pkg;

   localparam int MAX_N_IN = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      SWEEP = 1'b1
   } state_t;

endpackage

// File: rtl/minterm_lut.sv
// minterm_lut: truth-table register with one write port and two
// combinational read ports (point evaluation and sweep index).
module minterm_lut #(
   parameter  int N_IN  = 2,
   localparam int TBL_W = 2**N_IN
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we,
   input  logic [TBL_W-1:0] din,
   input  logic [N_IN-1:0]  eval_x,
   input  logic [N_IN-1:0]  sweep_x,
   output logic             eval_f,
   output logic             sweep_f
);

   logic [TBL_W-1:0] tbl;

   // Table register; the caller gates we so the table is frozen while sweeping.
   always_ff @(posedge clk) begin
      if (!rst_n) tbl <= '0;
      else if (we) tbl <= din;
   end

   assign eval_f  = tbl[eval_x];
   assign sweep_f = tbl[sweep_x];

endmodule

// File: rtl/minterm_sweeper.sv
// minterm_sweeper: programmable N-input truth-table evaluator with a
// one-cycle point-evaluation path and a valid/ready full-table sweep.
// Optional feature: define MINTERM_COUNT_EN to add the ones_cnt counter.
module minterm_sweeper
   import minterm_pkg::*;
#(
   parameter  int N_IN  = 2,
   localparam int TBL_W = 2**N_IN
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tbl_we,
   input  logic [TBL_W-1:0] tbl_in,
   input  logic             eval_valid,
   input  logic [N_IN-1:0]  eval_x,
   output logic             eval_f_valid,
   output logic             eval_f,
   input  logic             sweep_start,
   output logic             busy,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [N_IN-1:0]  out_x,
   output logic             out_f,
   output logic             out_last
`ifdef MINTERM_COUNT_EN
   ,
   output logic [N_IN:0]    ones_cnt
`endif
);

   if (N_IN < 1 || N_IN > MAX_N_IN) begin : g_bad_n_in
      $error("minterm_sweeper: N_IN out of range 1..%0d", MAX_N_IN);
   end

   state_t          state;
   logic [N_IN-1:0] idx;
   logic            lut_eval_f;
   logic            lut_sweep_f;
   logic            xfer;
   logic            at_last;

   minterm_lut #(.N_IN(N_IN)) u_lut (
      .clk     (clk),
      .rst_n   (rst_n),
      .we      (tbl_we && (state == IDLE)),
      .din     (tbl_in),
      .eval_x  (eval_x),
      .sweep_x (idx),
      .eval_f  (lut_eval_f),
      .sweep_f (lut_sweep_f)
   );

   assign busy      = (state == SWEEP);
   assign at_last   = (idx == '1);
   assign out_valid = busy;
   assign out_x     = idx;
   assign out_f     = busy & lut_sweep_f;
   assign out_last  = busy & at_last;
   assign xfer      = out_valid & out_ready;

   // Eval path: registered read of the pre-edge table, value held when idle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         eval_f_valid <= 1'b0;
         eval_f       <= 1'b0;
      end else begin
         eval_f_valid <= eval_valid;
         if (eval_valid) eval_f <= lut_eval_f;
      end
   end

   // Sweep FSM and index counter; index advances only on an accepted beat.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         idx   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (sweep_start) begin
                  state <= SWEEP;
                  idx   <= '0;
               end
            end
            SWEEP: begin
               if (xfer) begin
                  if (at_last) begin
                     state <= IDLE;
                     idx   <= '0;
                  end else begin
                     idx <= idx + N_IN'(1);
                  end
               end
            end
            default: begin
               state <= IDLE;
               idx   <= '0;
            end
         endcase
      end
   end

`ifdef MINTERM_COUNT_EN
   // Count true minterms delivered in the current sweep; holds afterwards.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ones_cnt <= '0;
      end else if (state == IDLE) begin
         if (sweep_start) ones_cnt <= '0;
      end else if (xfer && lut_sweep_f) begin
         ones_cnt <= ones_cnt + (N_IN+1)'(1);
      end
   end
`endif

endmodule

// File: tb/tb_minterm_sweeper.sv
// tb_minterm_sweeper: scoreboard bench for minterm_sweeper (N_IN=2 main
// instance, N_IN=3 secondary instance for the one-hot table case).
module tb_minterm_sweeper;

   typedef struct packed {
      logic [1:0] x;
      logic       f;
      logic       last;
   } beat_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tbl_we = 1'b0;
   logic [3:0] tbl_in = '0;
   logic       eval_valid = 1'b0;
   logic [1:0] eval_x = '0;
   logic       eval_f_valid, eval_f;
   logic       sweep_start = 1'b0;
   logic       busy, out_valid, out_f, out_last;
   logic       out_ready = 1'b1;
   logic [1:0] out_x;
   logic [2:0] ones_cnt;

   logic       tbl_we3 = 1'b0;
   logic [7:0] tbl_in3 = '0;
   logic       sweep_start3 = 1'b0;
   logic       eval_f_valid3, eval_f3, busy3, out_valid3, out_f3, out_last3;
   logic [2:0] out_x3;
   logic [3:0] ones_cnt3;

   int n_chk = 0;
   int n_fail = 0;
   int nbeats = 0;
   int nevals = 0;
   beat_t bq[$];
   logic  eq[$];
   logic [3:0] tm = '0;

   always #5 clk = ~clk;

   minterm_sweeper #(.N_IN(2)) dut (
      .clk(clk), .rst_n(rst_n), .tbl_we(tbl_we), .tbl_in(tbl_in),
      .eval_valid(eval_valid), .eval_x(eval_x),
      .eval_f_valid(eval_f_valid), .eval_f(eval_f),
      .sweep_start(sweep_start), .busy(busy), .out_valid(out_valid),
      .out_ready(out_ready), .out_x(out_x), .out_f(out_f), .out_last(out_last)
`ifdef MINTERM_COUNT_EN
      , .ones_cnt(ones_cnt)
`endif
   );

   minterm_sweeper #(.N_IN(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .tbl_we(tbl_we3), .tbl_in(tbl_in3),
      .eval_valid(1'b0), .eval_x(3'd0),
      .eval_f_valid(eval_f_valid3), .eval_f(eval_f3),
      .sweep_start(sweep_start3), .busy(busy3), .out_valid(out_valid3),
      .out_ready(1'b1), .out_x(out_x3), .out_f(out_f3), .out_last(out_last3)
`ifdef MINTERM_COUNT_EN
      , .ones_cnt(ones_cnt3)
`endif
   );

`ifndef MINTERM_COUNT_EN
   assign ones_cnt  = '0;
   assign ones_cnt3 = '0;
`endif

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [3:0] t);
      tbl_we = 1'b1; tbl_in = t;
      tick;
      tbl_we = 1'b0;
      tm = t;
   endtask

   task automatic push_beats(input logic [3:0] t);
      beat_t b;
      for (int i = 0; i < 4; i++) begin
         b.x = 2'(i); b.f = t[i]; b.last = (i == 3);
         bq.push_back(b);
      end
   endtask

   // stall: out_ready low for that many cycles starting at x=2
   // inj: write zeros + re-start during x=1 (must be ignored)
   // wr: write wdat on the same edge as sweep_start
   task automatic do_sweep(input int stall, input bit inj, input bit wr, input logic [3:0] wdat);
      int n, b0, ones;
      if (wr) tm = wdat;
      push_beats(tm);
      ones = $countones(tm);
      b0 = nbeats;
      sweep_start = 1'b1; tbl_we = wr; tbl_in = wdat;
      tick;
      sweep_start = 1'b0; tbl_we = 1'b0;
      chk("busy_after_start", busy, 1);
      n = 0;
      while (busy && n < 50) begin
         out_ready = !(n >= 2 && n < 2 + stall);
         if (inj && n == 1) begin
            tbl_we = 1'b1; tbl_in = 4'b0000; sweep_start = 1'b1;
         end
         tick;
         tbl_we = 1'b0; sweep_start = 1'b0;
         n++;
      end
      out_ready = 1'b1;
      chk("sweep_cycles", n, 4 + stall);
      chk("sweep_transfers", nbeats - b0, 4);
      chk("sweep_queue_empty", bq.size(), 0);
      chk("busy_low_after", busy, 0);
      chk("out_valid_idle", out_valid, 0);
      chk("out_last_idle", out_last, 0);
`ifdef MINTERM_COUNT_EN
      chk("ones_cnt", ones_cnt, ones);
`endif
   endtask

   // Scoreboard: compare beats (including stable hold while stalled) and evals.
   always @(negedge clk) begin
      if (out_valid) begin
         if (bq.size() == 0) begin
            chk("beat_unexpected", out_valid, 0);
         end else begin
            chk("beat_x", out_x, bq[0].x);
            chk("beat_f", out_f, bq[0].f);
            chk("beat_last", out_last, bq[0].last);
            if (out_ready) begin
               void'(bq.pop_front());
               nbeats++;
            end
         end
      end
      if (eval_f_valid) begin
         if (eq.size() == 0) chk("eval_unexpected", eval_f_valid, 0);
         else chk("eval_f", eval_f, eq.pop_front());
         nevals++;
      end
   end

   initial begin
      logic [1:0] exs[5];
      int e0;
      exs[0] = 2'd1; exs[1] = 2'd2; exs[2] = 2'd3; exs[3] = 2'd0; exs[4] = 2'd2;

      // Reset state
      tick; tick;
      chk("rst_busy", busy, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_x", out_x, 0);
      chk("rst_out_f", out_f, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_eval_f_valid", eval_f_valid, 0);
      chk("rst_eval_f", eval_f, 0);
      rst_n = 1'b1;
      tick;

      // Back-to-back evals, then hold
      load(4'b0110);
      e0 = nevals;
      eval_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         eval_x = exs[i];
         eq.push_back(tm[exs[i]]);
         tick;
      end
      eval_valid = 1'b0;
      tick; tick;
      chk("eval_count", nevals - e0, 5);
      chk("eval_f_hold", eval_f, 1);
      chk("eval_f_valid_low", eval_f_valid, 0);

      // Eval on the same edge as a table write sees the old table
      eval_valid = 1'b1; eval_x = 2'd0; eq.push_back(tm[0]);
      tbl_we = 1'b1; tbl_in = 4'b1111;
      tick;
      tm = 4'b1111;
      tbl_we = 1'b0; eval_x = 2'd0; eq.push_back(tm[0]);
      tick;
      eval_valid = 1'b0;
      tick;
      chk("eval_queue_empty", eq.size(), 0);

      // Full sweep, all ones
      do_sweep(0, 1'b0, 1'b0, 4'b0000);

      // Backpressure at x=2
      load(4'b0110);
      do_sweep(3, 1'b0, 1'b0, 4'b0000);

      // Write and re-start during a sweep are ignored
      do_sweep(0, 1'b1, 1'b0, 4'b0000);

      // Write + start together in IDLE: sweep reads the new table
      do_sweep(0, 1'b0, 1'b1, 4'b0000);

      // Reset mid-sweep at x=1
      load(4'b0110);
      push_beats(tm);
      e0 = nbeats;
      sweep_start = 1'b1;
      tick;
      sweep_start = 1'b0;
      tick;
      chk("pre_rst_x", out_x, 1);
      out_ready = 1'b0; rst_n = 1'b0;
      tick;
      rst_n = 1'b1; out_ready = 1'b1;
      bq.delete();
      tm = 4'b0000;
      chk("midrst_transfers", nbeats - e0, 1);
      chk("midrst_busy", busy, 0);
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_out_x", out_x, 0);
      chk("midrst_out_f", out_f, 0);
      chk("midrst_out_last", out_last, 0);
      chk("midrst_eval_f", eval_f, 0);
`ifdef MINTERM_COUNT_EN
      chk("midrst_ones_cnt", ones_cnt, 0);
`endif
      tick;
      chk("midrst_no_beats", bq.size(), 0);
      load(4'b0110);
      do_sweep(0, 1'b0, 1'b0, 4'b0000);

      // N_IN=3, one-hot table at x=7
      tbl_we3 = 1'b1; tbl_in3 = 8'h80;
      tick;
      tbl_we3 = 1'b0; sweep_start3 = 1'b1;
      tick;
      sweep_start3 = 1'b0;
      for (int x = 0; x < 8; x++) begin
         chk("n3_valid", out_valid3, 1);
         chk("n3_x", out_x3, x);
         chk("n3_f", out_f3, (x == 7));
         chk("n3_last", out_last3, (x == 7));
         tick;
      end
      chk("n3_busy_after", busy3, 0);
`ifdef MINTERM_COUNT_EN
      chk("n3_ones_cnt", ones_cnt3, 1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
